des_cbc_controller: RTL and testbench

Sequencing controller that runs the combinational DES encryption core in CBC mode over a stream of 64-bit blocks. It latches key and initial IV on a start command and feeds one plaintext block at a time to the core. It holds core operands stable for a programmable multicycle settle window, then captures the ciphertext and chains it back as the next IV. It sits between a block source/sink (valid/ready streams) and a single `DES_Encrypt` instance, replacing bench-driven IV chaining with synthesizable control.

---
 rtl/des_cbc_controller_if.sv | 38 +++
 rtl/des_cbc_controller.sv | 115 +++++++++++
 tb/tb_des_cbc_controller.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_cbc_controller_if.sv
`default_nettype none
// ============================================================================
// des_cbc_controller_if : job command, block streams and DES core operands
// Rev 1.0
// ============================================================================
interface des_cbc_controller_if #(
  parameter int CNT_W = 18
);
  logic             start;
  logic [64:1]      key;
  logic [64:1]      iv_init;
  logic [CNT_W-1:0] num_blocks;
  logic             in_valid;
  logic             in_ready;
  logic [64:1]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [64:1]      out_data;
  logic [64:1]      core_msg;
  logic [64:1]      core_key;
  logic [64:1]      core_iv;
  logic [64:1]      core_ct;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] blk_idx;

  // master is the block source/sink plus the DES core; slave is the controller
  modport master (
    output start, key, iv_init, num_blocks, in_valid, in_data, out_ready, core_ct,
    input  in_ready, out_valid, out_data, core_msg, core_key, core_iv, busy, done, blk_idx
  );

  modport slave (
    input  start, key, iv_init, num_blocks, in_valid, in_data, out_ready, core_ct,
    output in_ready, out_valid, out_data, core_msg, core_key, core_iv, busy, done, blk_idx
  );
endinterface
`default_nettype wire

// File: rtl/des_cbc_controller.sv
`default_nettype none
// ============================================================================
// des_cbc_controller : CBC sequencer around a combinational DES_Encrypt core
// Rev 1.0
// ============================================================================
module des_cbc_controller #(
  parameter int WAIT_CYCLES = 4,
  parameter int CNT_W       = 18
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  des_cbc_controller_if.slave bus
);
  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [64:1]      key_q, key_d;
  logic [64:1]      iv_q, iv_d;
  logic [64:1]      msg_q, msg_d;
  logic [64:1]      out_q, out_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] blk_inc;
  logic [7:0]       wait_q, wait_d;

  assign blk_inc = blk_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      iv_q    <= '0;
      msg_q   <= '0;
      out_q   <= '0;
      num_q   <= '0;
      blk_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      iv_q    <= iv_d;
      msg_q   <= msg_d;
      out_q   <= out_d;
      num_q   <= num_d;
      blk_q   <= blk_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    iv_d    = iv_q;
    msg_d   = msg_q;
    out_d   = out_q;
    num_d   = num_q;
    blk_d   = blk_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          key_d   = bus.key;
          iv_d    = bus.iv_init;
          num_d   = bus.num_blocks;
          blk_d   = '0;
          state_d = (bus.num_blocks == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          msg_d   = bus.in_data;
          wait_d  = WAIT_INIT;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // operands have been stable for WAIT_CYCLES edges when wait_q reaches 0
        if (wait_q == 8'd0) begin
          out_d   = bus.core_ct;
          state_d = S_OUT;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          iv_d    = out_q;
          blk_d   = blk_inc;
          state_d = (blk_inc == num_q) ? S_DONE : S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.out_data  = out_q;
  assign bus.blk_idx   = blk_q;
  assign bus.core_msg  = msg_q;
  assign bus.core_key  = key_q;
  assign bus.core_iv   = iv_q;
endmodule
`default_nettype wire

// File: tb/tb_des_cbc_controller.sv
`default_nettype none
// tb_des_cbc_controller : job table, hand-written corner cases and a CBC stream
// checked against a block-level reference model; the DES core is a settle-aware stand-in.
module tb_des_cbc_controller;
  localparam int          WA      = 4;
  localparam int          WB      = 1;
  localparam int          NS      = 2000;
  localparam int          NJ      = 6;
  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  always #5 clk = ~clk;

  des_cbc_controller_if #(.CNT_W(18)) a_if ();
  des_cbc_controller_if #(.CNT_W(18)) b_if ();

  des_cbc_controller #(.WAIT_CYCLES(WA), .CNT_W(18)) dut_a (.clk(clk), .rst_n(rst_a_n), .bus(a_if));
  des_cbc_controller #(.WAIT_CYCLES(WB), .CNT_W(18)) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(b_if));

  int checks   = 0;
  int failures = 0;

  // Exact for the reference DES vector, keyed nonlinear mixing for everything else
  function automatic logic [63:0] core_fn(input logic [63:0] m, input logic [63:0] k,
                                          input logic [63:0] iv);
    logic [63:0] x;
    x = m ^ iv;
    if (x == KAT_PT && k == KAT_KEY) return KAT_CT;
    for (int r = 0; r < 4; r++)
      x = {x[31:0], x[63:32] ^ (((x[31:0] ^ k[63:32]) * 32'h9E3779B9) + k[31:0] + 32'(r))};
    return x;
  endfunction

  // Core A only presents a correct result once its operands have been held WA cycles
  logic [191:0] ops_a;
  logic [191:0] prev_a = '0;
  int           stab_a = 0;
  int           held_a;
  assign ops_a = {a_if.core_msg, a_if.core_key, a_if.core_iv};
  always @(posedge clk) begin
    if (ops_a != prev_a)   stab_a <= 0;
    else if (stab_a < 1000) stab_a <= stab_a + 1;
    prev_a <= ops_a;
  end
  assign held_a       = (ops_a != prev_a) ? 1 : stab_a + 2;
  assign a_if.core_ct = (held_a >= WA) ? core_fn(a_if.core_msg, a_if.core_key, a_if.core_iv)
                                       : ~core_fn(a_if.core_msg, a_if.core_key, a_if.core_iv);
  assign b_if.core_ct = core_fn(b_if.core_msg, b_if.core_key, b_if.core_iv);

  typedef struct {
    logic [63:0] key;
    logic [63:0] iv;
    int          nblk;
    bit          gaps;
    logic [63:0] exp_last;
    int          exp_cyc;
  } job_t;

  job_t        jobs [NJ];
  logic [63:0] jpt  [NJ][16];
  logic [63:0] spt  [NS];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_a(input string nm, output int lat);
    lat = 0;
    while (!a_if.out_valid && lat < 100) begin
      tick;
      lat++;
    end
    chk(nm, a_if.out_valid, 1);
  endtask

  function automatic job_t mk(input logic [63:0] k, input logic [63:0] iv, input int n,
                              input bit g);
    job_t t;
    t.key = k; t.iv = iv; t.nblk = n; t.gaps = g;
    t.exp_last = '0; t.exp_cyc = n * (WA + 2) + 1;
    return t;
  endfunction

  task automatic run_job(input int j);
    logic [63:0] chain, exp;
    int sent, got, cyc, extra_rdy, overlap;
    bit seen_done;
    chk("idle_before_start", a_if.busy, 0);
    a_if.key = jobs[j].key; a_if.iv_init = jobs[j].iv;
    a_if.num_blocks = 18'(jobs[j].nblk);
    a_if.start = 1'b1;
    tick;
    a_if.start = 1'b0;
    chain = jobs[j].iv; sent = 0; got = 0; extra_rdy = 0; overlap = 0; seen_done = 0;
    for (cyc = 1; cyc < 2000; cyc++) begin
      if (a_if.done) begin
        seen_done = 1;
        break;
      end
      if (jobs[j].gaps) begin
        a_if.in_valid   = (sent < jobs[j].nblk) && ($urandom_range(0, 2) != 0);
        a_if.out_ready  = ($urandom_range(0, 2) != 0);
        a_if.start      = ($urandom_range(0, 3) == 0);
        a_if.key        = {$urandom, $urandom};
        a_if.num_blocks = 18'($urandom_range(0, 7));
      end else begin
        a_if.in_valid  = (sent < jobs[j].nblk);
        a_if.out_ready = 1'b1;
      end
      a_if.in_data = jpt[j][(sent < 16) ? sent : 15];
      if (a_if.in_ready && sent >= jobs[j].nblk) extra_rdy++;
      if (a_if.in_ready && a_if.out_valid) overlap++;
      if (a_if.in_valid && a_if.in_ready) begin
        chk("core_iv_at_load", a_if.core_iv, chain);
        chk("core_key_at_load", a_if.core_key, jobs[j].key);
        chk("blk_idx_at_load", a_if.blk_idx, 64'(got));
        sent++;
      end
      if (a_if.out_valid && a_if.out_ready) begin
        exp = core_fn(jpt[j][got], jobs[j].key, chain);
        chk("ct", a_if.out_data, exp);
        chain = exp;
        got++;
      end
      tick;
    end
    a_if.start = 1'b0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("busy_at_done", a_if.busy, 1);
    chk("blocks_out", 64'(got), 64'(jobs[j].nblk));
    chk("blk_idx_final", a_if.blk_idx, 64'(jobs[j].nblk));
    chk("no_extra_in_ready", 64'(extra_rdy), 0);
    chk("no_stream_overlap", 64'(overlap), 0);
    if (jobs[j].nblk > 0) chk("last_ct", a_if.out_data, jobs[j].exp_last);
    if (!jobs[j].gaps) chk("job_cycles", 64'(cyc), 64'(jobs[j].exp_cyc));
    tick;
    chk("done_one_cycle", a_if.done, 0);
    chk("busy_after_done", a_if.busy, 0);
  endtask

  initial begin
    logic [63:0] chain, exp, d0, iv0, k0;
    int lat, bad, bs, bg, last, badp;
    bit sdone;

    for (int j = 0; j < NJ; j++)
      for (int i = 0; i < 16; i++) jpt[j][i] = {$urandom, $urandom};
    jobs[0] = mk(KAT_KEY, 64'h0, 2, 1'b0);
    jobs[1] = mk(KAT_KEY, {$urandom, $urandom}, 0, 1'b0);
    jobs[2] = mk({$urandom, $urandom}, {$urandom, $urandom}, 3, 1'b1);
    jobs[3] = mk({$urandom, $urandom}, {$urandom, $urandom}, 5, 1'b0);
    jobs[4] = mk({$urandom, $urandom}, {$urandom, $urandom}, 16, 1'b1);
    jobs[5] = mk(KAT_KEY, 64'h0, 1, 1'b0);
    jpt[0][0] = KAT_PT; jpt[0][1] = 64'h84CB563386A179EA; jobs[0].exp_last = KAT_CT;
    jpt[5][0] = KAT_PT; jobs[5].exp_last = KAT_CT;
    for (int j = 1; j <= 4; j++) begin
      chain = jobs[j].iv;
      for (int i = 0; i < jobs[j].nblk; i++) chain = core_fn(jpt[j][i], jobs[j].key, chain);
      jobs[j].exp_last = chain;
    end

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    a_if.start = 0; a_if.key = '0; a_if.iv_init = '0; a_if.num_blocks = '0;
    a_if.in_valid = 0; a_if.in_data = '0; a_if.out_ready = 0;
    b_if.start = 0; b_if.key = '0; b_if.iv_init = '0; b_if.num_blocks = '0;
    b_if.in_valid = 0; b_if.in_data = '0; b_if.out_ready = 0;
    tick; tick;
    chk("rst_in_ready", a_if.in_ready, 0);
    chk("rst_out_valid", a_if.out_valid, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_blk_idx", a_if.blk_idx, 0);
    chk("rst_out_data", a_if.out_data, 0);
    chk("rst_core_msg", a_if.core_msg, 0);
    chk("rst_core_key", a_if.core_key, 0);
    chk("rst_core_iv", a_if.core_iv, 0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    tick;

    // ECB sanity with exact latency
    a_if.key = KAT_KEY; a_if.iv_init = '0; a_if.num_blocks = 18'd1; a_if.start = 1'b1;
    tick;
    a_if.start = 1'b0;
    chk("ecb_in_ready_after_start", a_if.in_ready, 1);
    a_if.in_valid = 1'b1; a_if.in_data = KAT_PT;
    tick;
    a_if.in_valid = 1'b0;
    wait_out_a("ecb_out_valid", lat);
    chk("ecb_latency", 64'(lat), 64'(WA));
    chk("ecb_ct", a_if.out_data, KAT_CT);
    a_if.out_ready = 1'b1;
    tick;
    a_if.out_ready = 1'b0;
    chk("ecb_done", a_if.done, 1);
    tick;
    chk("ecb_done_gone", a_if.done, 0);
    chk("ecb_busy_low", a_if.busy, 0);

    for (int j = 0; j < 5; j++) run_job(j);

    // Backpressure: OUT held for 10 cycles
    k0 = {$urandom, $urandom}; iv0 = {$urandom, $urandom}; d0 = {$urandom, $urandom};
    a_if.key = k0; a_if.iv_init = iv0; a_if.num_blocks = 18'd1; a_if.start = 1'b1;
    tick;
    a_if.start = 1'b0; a_if.in_valid = 1'b1; a_if.in_data = d0;
    tick;
    a_if.in_valid = 1'b0;
    wait_out_a("bp_out_valid", lat);
    exp = core_fn(d0, k0, iv0);
    chk("bp_ct", a_if.out_data, exp);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (a_if.out_valid !== 1'b1 || a_if.out_data !== exp || a_if.in_ready !== 1'b0 ||
          a_if.core_iv !== iv0 || a_if.blk_idx !== 18'd0) bad++;
    end
    chk("bp_hold_stable", 64'(bad), 0);
    a_if.out_ready = 1'b1;
    tick;
    a_if.out_ready = 1'b0;
    chk("bp_iv_updated", a_if.core_iv, exp);
    chk("bp_done", a_if.done, 1);
    tick;

    // Reset during RUN of block 2
    a_if.key = k0; a_if.iv_init = iv0; a_if.num_blocks = 18'd3; a_if.start = 1'b1;
    tick;
    a_if.start = 1'b0; a_if.in_valid = 1'b1; a_if.in_data = d0;
    tick;
    a_if.in_valid = 1'b0;
    wait_out_a("rr_out_valid", lat);
    a_if.out_ready = 1'b1;
    tick;
    a_if.out_ready = 1'b0; a_if.in_valid = 1'b1; a_if.in_data = ~d0;
    tick;
    a_if.in_valid = 1'b0;
    tick;
    chk("rr_in_run", a_if.busy, 1);
    rst_a_n = 1'b0;
    tick;
    rst_a_n = 1'b1;
    chk("rr_in_ready", a_if.in_ready, 0);
    chk("rr_out_valid", a_if.out_valid, 0);
    chk("rr_busy", a_if.busy, 0);
    chk("rr_done", a_if.done, 0);
    chk("rr_blk_idx", a_if.blk_idx, 0);
    chk("rr_out_data", a_if.out_data, 0);
    chk("rr_core_msg", a_if.core_msg, 0);
    chk("rr_core_key", a_if.core_key, 0);
    chk("rr_core_iv", a_if.core_iv, 0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (a_if.done !== 1'b0 || a_if.busy !== 1'b0) bad++;
    end
    chk("rr_no_done", 64'(bad), 0);
    run_job(5);

    // Streaming on the WAIT_CYCLES=1 instance
    for (int i = 0; i < NS; i++) spt[i] = {$urandom, $urandom};
    b_if.key = KAT_KEY; b_if.iv_init = KAT_KEY; b_if.num_blocks = 18'(NS);
    b_if.in_valid = 1'b1; b_if.out_ready = 1'b1; b_if.start = 1'b1;
    tick;
    b_if.start = 1'b0;
    chain = KAT_KEY; bs = 0; bg = 0; last = 0; badp = 0; sdone = 0;
    for (int c = 1; c < NS * 3 + 50; c++) begin
      if (b_if.done) begin
        sdone = 1;
        break;
      end
      b_if.in_data = spt[(bs < NS) ? bs : NS - 1];
      if (b_if.in_valid && b_if.in_ready) bs++;
      if (b_if.out_valid && b_if.out_ready) begin
        exp = core_fn(spt[bg], KAT_KEY, chain);
        chk("stream_ct", b_if.out_data, exp);
        if (bg > 0 && c - last != WB + 2) badp++;
        last = c;
        chain = exp;
        bg++;
      end
      tick;
    end
    b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;
    chk("stream_done", sdone, 1);
    chk("stream_count", 64'(bg), 64'(NS));
    chk("stream_period", 64'(badp), 0);
    chk("stream_blk_idx", b_if.blk_idx, 64'(NS));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
